// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and the base-op decode default.
// The M ops are only built when SEQ_ALU_MULDIV_EN is defined.
package seq_alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'b00000,
        OP_SLL    = 5'b00001,
        OP_SLT    = 5'b00010,
        OP_SLTU   = 5'b00011,
        OP_XOR    = 5'b00100,
        OP_SRL    = 5'b00101,
        OP_OR     = 5'b00110,
        OP_AND    = 5'b00111,
        OP_SUB    = 5'b01000,
        OP_COPYA  = 5'b01001,
        OP_SRA    = 5'b01101,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Replicated across the datapath width for any undecoded base op.
    localparam logic BASE_DEFAULT = 1'b0;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative shift-add multiplier and restoring divider sharing one 2*WIDTH partial register.
// Signed ops run on magnitudes; the sign is reapplied to the final step's value.
module iter_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             busy,
    input  logic [2:0]       fun,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_step;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;
    logic [CW-1:0]      count;
    logic [2:0]         fun_q;
    logic               neg;
    logic               neg_start;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;

    // Operand signedness follows RISC-V: MULH/DIV/REM both signed, MULHSU only A.
    always_comb begin
        a_neg     = a[WIDTH-1] & ((fun == 3'b001) | (fun == 3'b010) | (fun == 3'b100) | (fun == 3'b110));
        b_neg     = b[WIDTH-1] & ((fun == 3'b001) | (fun == 3'b100) | (fun == 3'b110));
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        neg_start = (fun[2] & fun[1]) ? a_neg : (a_neg ^ b_neg);
    end

    // Multiply keeps the multiplier in the low half; divide keeps {remainder, quotient}.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift = prod[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd};
        div_ok    = ~div_diff[WIDTH];
        if (fun_q[2]) begin
            prod_step = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), prod[WIDTH-2:0], div_ok};
        end else begin
            prod_step = {mul_sum, prod[WIDTH-1:1]};
        end
        prod_signed = neg ? -prod_step : prod_step;
        quo_signed  = neg ? -prod_step[WIDTH-1:0] : prod_step[WIDTH-1:0];
        rem_signed  = neg ? -prod_step[2*WIDTH-1:WIDTH] : prod_step[2*WIDTH-1:WIDTH];
        if (fun_q[2]) begin
            result = fun_q[1] ? rem_signed : quo_signed;
        end else begin
            result = (fun_q[1:0] == 2'b00) ? prod_signed[WIDTH-1:0] : prod_signed[2*WIDTH-1:WIDTH];
        end
        last = busy & (count == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod  <= '0;
            opnd  <= '0;
            count <= '0;
            fun_q <= '0;
            neg   <= 1'b0;
        end else if (start) begin
            prod  <= {{WIDTH{1'b0}}, (fun[2] ? a_mag : b_mag)};
            opnd  <= fun[2] ? b_mag : a_mag;
            count <= CW'(WIDTH - 1);
            fun_q <= fun;
            neg   <= neg_start;
        end else if (busy) begin
            prod <= prod_step;
            if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes; base ops resolve in one cycle.
// Define SEQ_ALU_MULDIV_EN to build the iterative M ops, otherwise they return 0.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       ALU_FUN,
    input  logic             VALID_IN,
    output logic             READY_OUT,
    output logic [WIDTH-1:0] RESULT,
    output logic             VALID_OUT,
    input  logic             READY_IN
);

    localparam int SW = $clog2(WIDTH);

    state_e           state;
    state_e           state_next;
    logic [WIDTH-1:0] result_next;
    logic [WIDTH-1:0] base_res;
    logic [SW-1:0]    shamt;

    always_comb begin
        shamt    = B[SW-1:0];
        base_res = {WIDTH{BASE_DEFAULT}};
        case (alu_op_e'(ALU_FUN))
            OP_ADD:   base_res = A + B;
            OP_SUB:   base_res = A - B;
            OP_OR:    base_res = A | B;
            OP_AND:   base_res = A & B;
            OP_XOR:   base_res = A ^ B;
            OP_SRL:   base_res = A >> shamt;
            OP_SLL:   base_res = A << shamt;
            OP_SRA:   base_res = $signed(A) >>> shamt;
            OP_SLT:   base_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU:  base_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_COPYA: base_res = A;
            default:  base_res = {WIDTH{BASE_DEFAULT}};
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             md_start;
    logic             md_busy;
    logic             md_last;
    logic [WIDTH-1:0] md_result;
    logic             div_zero;
    logic             div_ovf;
    logic             m_special;
    logic [WIDTH-1:0] m_special_res;

    // Divide-by-zero and signed overflow bypass the iterative datapath entirely.
    always_comb begin
        div_zero      = (B == '0);
        div_ovf       = ~ALU_FUN[0] & (A == MOST_NEG) & (B == '1);
        m_special     = ALU_FUN[2] & (div_zero | div_ovf);
        m_special_res = ~ALU_FUN[1] ? (div_zero ? '1 : A) : (div_zero ? A : '0);
        md_busy       = (state == MUL) | (state == DIV);
    end

    iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter_muldiv (
        .clk    (CLK),
        .rst    (RST),
        .start  (md_start),
        .busy   (md_busy),
        .fun    (ALU_FUN[2:0]),
        .a      (A),
        .b      (B),
        .last   (md_last),
        .result (md_result)
    );
`endif

    always_comb begin
        state_next  = state;
        result_next = RESULT;
`ifdef SEQ_ALU_MULDIV_EN
        md_start    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (VALID_IN) begin
                    state_next = DONE;
                    if (!ALU_FUN[4]) begin
                        result_next = base_res;
`ifdef SEQ_ALU_MULDIV_EN
                    end else if (m_special) begin
                        result_next = m_special_res;
                    end else begin
                        md_start   = 1'b1;
                        state_next = ALU_FUN[2] ? DIV : MUL;
                    end
`else
                    end else begin
                        result_next = {WIDTH{BASE_DEFAULT}};
                    end
`endif
                end
            end
`ifdef SEQ_ALU_MULDIV_EN
            MUL, DIV: begin
                if (md_last) begin
                    result_next = md_result;
                    state_next  = DONE;
                end
            end
`endif
            DONE: begin
                if (READY_IN) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            RESULT <= '0;
        end else begin
            state  <= state_next;
            RESULT <= result_next;
        end
    end

    assign READY_OUT = (state == IDLE);
    assign VALID_OUT = (state == DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=32; M-op expectations follow SEQ_ALU_MULDIV_EN.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 32;
`ifdef SEQ_ALU_MULDIV_EN
    localparam bit MD_ON = 1'b1;
`else
    localparam bit MD_ON = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [4:0]   ALU_FUN = '0;
    logic         VALID_IN = 1'b0;
    logic         READY_OUT;
    logic [W-1:0] RESULT;
    logic         VALID_OUT;
    logic         READY_IN = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];
    int           lat_q[$];

    seq_alu #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .B         (B),
        .ALU_FUN   (ALU_FUN),
        .VALID_IN  (VALID_IN),
        .READY_OUT (READY_OUT),
        .RESULT    (RESULT),
        .VALID_OUT (VALID_OUT),
        .READY_IN  (READY_IN)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // M-op expectation when built in, else the disabled-build 0 result.
    function automatic logic [W-1:0] md_exp(input logic [W-1:0] v);
        return MD_ON ? v : '0;
    endfunction

    function automatic int md_lat(input bit iterative);
        return (MD_ON && iterative) ? W + 1 : 1;
    endfunction

    task automatic issue_op(input string name, input logic [4:0] fun, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp, input int lat,
                            output int acc);
        @(negedge CLK);
        total++;
        if (READY_OUT !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s ready_before_issue got=%b want=1", name, READY_OUT);
        end
        A = a;
        B = b;
        ALU_FUN = fun;
        VALID_IN = 1'b1;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        @(posedge CLK);
        #1;
        acc = cyc;
        VALID_IN = 1'b0;
    endtask

    task automatic collect(input string name, input int acc);
        int waited;
        int lat_want;
        int lat_got;
        logic [W-1:0] res_want;
        waited = 0;
        while (VALID_OUT !== 1'b1 && waited < 200) begin
            @(posedge CLK);
            #1;
            waited++;
        end
        res_want = exp_q.pop_front();
        lat_want = lat_q.pop_front();
        lat_got = cyc - acc + 1;
        total++;
        if (VALID_OUT !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s timeout got valid=%b want=1", name, VALID_OUT);
        end else begin
            total++;
            if (lat_got !== lat_want) begin
                bad++;
                $display("[TB] FAIL %s latency got=%0d want=%0d", name, lat_got, lat_want);
            end
            if (RESULT !== res_want) begin
                bad++;
                $display("[TB] FAIL %s result got=%h want=%h", name, RESULT, res_want);
            end
        end
    endtask

    task automatic release_result(input string name);
        @(negedge CLK);
        READY_IN = 1'b1;
        @(posedge CLK);
        #1;
        READY_IN = 1'b0;
        total++;
        if (VALID_OUT !== 1'b0 || READY_OUT !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s release got valid=%b ready=%b want valid=0 ready=1",
                     name, VALID_OUT, READY_OUT);
        end
    endtask

    task automatic run_case(input string name, input logic [4:0] fun, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
        int acc;
        issue_op(name, fun, a, b, exp, lat, acc);
        collect(name, acc);
        release_result(name);
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (RESULT !== '0 || VALID_OUT !== 1'b0 || READY_OUT !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_state got result=%h valid=%b ready=%b want 0/0/1",
                     RESULT, VALID_OUT, READY_OUT);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        total++;
        if (READY_OUT !== 1'b1 || VALID_OUT !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release got ready=%b valid=%b want 1/0", READY_OUT, VALID_OUT);
        end
    endtask

    task automatic test_base_ops();
        run_case("add_wrap", OP_ADD,   32'h7FFFFFFF, 32'h1,        32'h80000000, 1);
        run_case("sub",      OP_SUB,   32'h5,        32'h7,        32'hFFFFFFFE, 1);
        run_case("or",       OP_OR,    32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1);
        run_case("and",      OP_AND,   32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1);
        run_case("xor",      OP_XOR,   32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1);
        run_case("srl",      OP_SRL,   32'h80000000, 32'h24,       32'h08000000, 1);
        run_case("sll",      OP_SLL,   32'h1,        32'h21,       32'h2,        1);
        run_case("sra",      OP_SRA,   32'h80000000, 32'h24,       32'hF8000000, 1);
        run_case("slt_neg",  OP_SLT,   32'hFFFFFFFF, 32'h1,        32'h1,        1);
        run_case("slt_pos",  OP_SLT,   32'h1,        32'hFFFFFFFF, 32'h0,        1);
        run_case("sltu",     OP_SLTU,  32'h1,        32'hFFFFFFFF, 32'h1,        1);
        run_case("copya",    OP_COPYA, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 1);
        run_case("undef_0a", 5'b01010, 32'h12345678, 32'h1,        32'h0,        1);
        run_case("undef_0f", 5'b01111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1);
    endtask

    task automatic test_muldiv();
        run_case("mulh",     OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, md_exp(32'h0),        md_lat(1));
        run_case("mulhu",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, md_exp(32'hFFFFFFFE), md_lat(1));
        run_case("mulhsu",   OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, md_exp(32'hFFFFFFFF), md_lat(1));
        run_case("mul_b3",   5'b11000,  32'h3,        32'h5,        md_exp(32'hF),        md_lat(1));
        run_case("div_neg",  OP_DIV,    32'hFFFFFFF9, 32'h2,        md_exp(32'hFFFFFFFD), md_lat(1));
        run_case("rem_neg",  OP_REM,    32'hFFFFFFF9, 32'h2,        md_exp(32'hFFFFFFFF), md_lat(1));
        run_case("divu",     OP_DIVU,   32'd100,      32'd7,        md_exp(32'd14),       md_lat(1));
        run_case("remu",     OP_REMU,   32'd100,      32'd7,        md_exp(32'd2),        md_lat(1));
        run_case("div_ovf",  OP_DIV,    32'h80000000, 32'hFFFFFFFF, md_exp(32'h80000000), md_lat(0));
        run_case("rem_ovf",  OP_REM,    32'h80000000, 32'hFFFFFFFF, md_exp(32'h0),        md_lat(0));
        run_case("div_zero", OP_DIV,    32'h1234,     32'h0,        md_exp(32'hFFFFFFFF), md_lat(0));
        run_case("remu_zero",OP_REMU,   32'h7,        32'h0,        md_exp(32'h7),        md_lat(0));
    endtask

    task automatic test_stall();
        int acc;
        issue_op("stall", OP_ADD, 32'd10, 32'd20, 32'd30, 1, acc);
        collect("stall", acc);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            VALID_IN = (i == 2);
            A = 32'h1;
            B = 32'h1;
            ALU_FUN = OP_SUB;
            @(posedge CLK);
            #1;
            VALID_IN = 1'b0;
            total++;
            if (VALID_OUT !== 1'b1 || RESULT !== 32'd30) begin
                bad++;
                $display("[TB] FAIL stall_hold_%0d got valid=%b result=%h want 1/%h",
                         i, VALID_OUT, RESULT, 32'd30);
            end
        end
        release_result("stall");
        @(posedge CLK);
        #1;
        total++;
        if (VALID_OUT !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_pulse_ignored got valid=%b want=0", VALID_OUT);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            if (i[0]) run_case("b2b_xor", OP_XOR, a, b, a ^ b, 1);
            else      run_case("b2b_add", OP_ADD, a, b, a + b, 1);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        int seen;
        issue_op("rst_divu", OP_DIVU, 32'hFFFFFFFF, 32'd3, 32'h55555555, md_lat(1), acc);
        repeat (9) @(posedge CLK);
        #1;
        total++;
        if (VALID_OUT !== !MD_ON) begin
            bad++;
            $display("[TB] FAIL rst_pre_valid got=%b want=%b", VALID_OUT, !MD_ON);
        end
        RST = 1'b1;
        #1;
        exp_q.delete();
        lat_q.delete();
        total++;
        if (VALID_OUT !== 1'b0 || RESULT !== '0 || READY_OUT !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_mid got valid=%b result=%h ready=%b want 0/0/1",
                     VALID_OUT, RESULT, READY_OUT);
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        total++;
        if (READY_OUT !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_ready_after got=%b want=1", READY_OUT);
        end
        seen = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (VALID_OUT === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("[TB] FAIL rst_aborted got valid_cycles=%0d want=0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_base_ops();
        test_muldiv();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        run_case("post_reset_add", OP_ADD, 32'd1, 32'd2, 32'd3, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have one clock and one reset: the clock port is CLK, and the reset port is RST, asynchronous and active-high.
REQ-002 Parameter WIDTH SHALL default to 32 and set the datapath width; legal values are 8, 16, 32 and 64.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- ALU_FUN  in  5  operation code (REQ-005)
- VALID_IN  in  1  operands and ALU_FUN are valid
- READY_OUT  out  1  block accepts a new operation
- RESULT  out  WIDTH  registered result
- VALID_OUT  out  1  RESULT is valid
- READY_IN  in  1  consumer takes RESULT

Function
REQ-004 An operation SHALL be accepted on a rising edge where VALID_IN and READY_OUT are both high; A, B and ALU_FUN SHALL be captured at that edge.
REQ-005 Op codes SHALL be decoded as follows:
- ALU_FUN[4]=0, base ops on ALU_FUN[3:0]: ADD 0000, SUB 1000, OR 0110, AND 0111, XOR 0100, SRL 0101, SLL 0001, SRA 1101, SLT 0010, SLTU 0011, COPY-A 1001.
- All other base codes SHALL produce 0.
- ALU_FUN[4]=1, M ops on ALU_FUN[2:0]: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- ALU_FUN[3] SHALL be ignored when ALU_FUN[4]=1.
REQ-006 Shift amounts SHALL use B[$clog2(WIDTH)-1:0] only; SLT/SLTU SHALL return zero-extended 0 or 1; arithmetic SHALL wrap modulo 2^WIDTH.
REQ-007 The FSM SHALL have the states IDLE, MUL, DIV and DONE; READY_OUT SHALL be high only in IDLE.
REQ-008 Transitions from IDLE on acceptance SHALL be:
- base op, or an M op hitting a REQ-011 special case -> DONE, with RESULT loaded at the accept edge.
- multiply op -> MUL.
- divide or remainder op -> DIV.
REQ-009 MUL and DIV SHALL iterate exactly WIDTH cycles (shift-add multiply, restoring divide), using a down-counter loaded with WIDTH-1, then enter DONE with RESULT loaded.
REQ-010 Latency SHALL be fixed:
- Base op accepted at edge N: VALID_OUT high after edge N.
- Iterative op accepted at edge N: VALID_OUT high after edge N+WIDTH.
REQ-011 Special cases SHALL resolve with 1-cycle latency:
- Divide by zero: DIV/DIVU -> all ones; REM/REMU -> A.
- Signed overflow (A=most-negative, B=-1): DIV -> A; REM -> 0.
REQ-012 MULH/MULHSU/MULHU SHALL return the upper WIDTH bits of the 2*WIDTH product with RISC-V signedness; MUL SHALL return the lower WIDTH bits.
REQ-013 DONE SHALL hold VALID_OUT high and RESULT stable until READY_IN is high at an edge, then go to IDLE; no new operation is accepted in that same cycle.
REQ-014 VALID_IN while not in IDLE SHALL be ignored and SHALL NOT disturb any in-flight operation.

Reset
REQ-015 RST high SHALL immediately force:
- state IDLE
- RESULT 0
- VALID_OUT 0
- counter 0
- all internal operand/partial registers 0
REQ-016 Reset asserted mid-operation SHALL abort that operation with no result produced; READY_OUT SHALL be high in the first cycle after RST deasserts.

Configuration
REQ-017 Macro SEQ_ALU_MULDIV_EN SHALL control the M ops:
- Defined: M ops behave per REQ-008 to REQ-012.
- Undefined: the MUL/DIV states and iterative datapath are not compiled; every ALU_FUN[4]=1 op returns 0 with base-op latency.

Structure
REQ-018 Package seq_alu_pkg SHALL hold:
- the 5-bit op-code enum
- the FSM state enum
- the constant for the base-op decode default (0)
REQ-019 The iterative multiply/divide datapath SHALL be a sub-module named iter_muldiv, instantiated only under SEQ_ALU_MULDIV_EN; the base ops SHALL stay inline in seq_alu.

Verification
REQ-020 ADD, WIDTH=32: A=0x7FFFFFFF, B=1 -> RESULT=0x80000000 with VALID_OUT one cycle after accept.
REQ-021 SRA: A=0x80000000, B=0x24 -> shift amount 4 -> RESULT=0xF8000000; SLTU with A=1, B=0xFFFFFFFF -> RESULT=1.
REQ-022 MULH: A=0xFFFFFFFF, B=0xFFFFFFFF -> RESULT=0 after 32+1 cycles; MULHU with the same operands -> RESULT=0xFFFFFFFE.
REQ-023 DIV: A=0x80000000, B=0xFFFFFFFF -> RESULT=0x80000000 at latency 1; REMU with A=7, B=0 -> RESULT=7.
REQ-024 READY_IN held low 5 cycles in DONE -> RESULT and VALID_OUT stable throughout; a VALID_IN pulse during that window is ignored.
REQ-025 RST asserted at cycle 10 of a DIVU -> VALID_OUT=0 and RESULT=0 immediately; READY_OUT=1 in the first cycle after release.
